nios2_debug_ocimem_ctrl: RTL
============================

Name: nios2_debug_ocimem_ctrl

Overview:
- On-chip debug memory (OCI RAM) controller, directly downstream of the debug-slave JTAG bridge.
- Consumes the bridge's system-clock strobes (take_action_ocimem_a/b, take_no_action_ocimem_a) and the 38-bit jdo payload.
- Serves JTAG reads and writes into a single-port debug RAM, returning read data on MonDReg.
- Arbitrates the same RAM against a CPU-side Avalon-MM slave used by the debug monitor code.

Parameters:
ADDR_W, 8, word-address width of debug RAM (legal 4..8); depth = 2**ADDR_W words of 32 bits

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jdo  in  38  JTAG payload from debug slave
take_action_ocimem_a  in  1  load address (jdo[ADDR_W+9:10]); jdo[35]=1 also requests read
take_action_ocimem_b  in  1  write jdo[34:3] at current address, then increment
take_no_action_ocimem_a  in  1  read at current address, then increment
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_byteenable  in  4  CPU byte enables
avs_debugaccess  in  1  CPU access from debug-mode code
avs_readdata  out  32  CPU read data
avs_waitrequest  out  1  CPU stall
MonDReg  out  32  last JTAG read data
mon_valid  out  1  one-cycle pulse when MonDReg updated
jtag_overrun  out  1  sticky: JTAG strobe dropped while one was pending

Behaviour:
- Reset (sync, clk edge with reset=1): state IDLE; JTAG address, pending flags, MonDReg, avs_readdata, mon_valid, jtag_overrun all 0; avs_waitrequest=1. RAM contents unchanged. Reset mid-operation abandons the operation: no write lands, no mon_valid.
- Strobe capture: at most one strobe is honoured per cycle, priority b > a > no_action_a. A captured strobe sets a pending JTAG op (RD or WR) with its address/data, effective the following cycle. A strobe arriving while a JTAG op is pending is dropped and sets jtag_overrun. take_action_ocimem_a clears jtag_overrun, including when it is itself dropped.
- take_action_ocimem_a with jdo[35]=0 loads the address only; no pending op is created.
- State machine:
  - IDLE: pending JTAG op has priority over a CPU request.
    - JTAG WR: RAM written this cycle, address += 1, stay IDLE.
    - JTAG RD: RAM read issued → JRD.
    - Otherwise, avs_read or avs_write asserted: access issued (write with byteenable) → CACK.
  - JRD: MonDReg <= RAM data, mon_valid=1, address += 1 for no_action reads only (address-load reads do not increment) → IDLE.
  - CACK: avs_waitrequest=0 for exactly this cycle; avs_readdata valid for reads → IDLE.
- avs_waitrequest = 1 in every state except CACK. CPU latency with no contention: request seen in cycle N, completes in N+1.
- The CPU master must hold its request until waitrequest=0. A JTAG op captured during a CPU wait is serviced first.
- Address arithmetic is modulo 2**ADDR_W: increment at all-ones wraps to 0.
- Strobe in the same cycle IDLE services the previous op: the previous op completes and the new strobe is captured (not an overrun, since the pending flag clears on that edge).

Optional Feature:
- Macro: OCIMEM_ROM_PROTECT_EN. Top quarter of the address space, addresses >= 3*2**(ADDR_W-2), is the monitor ROM region.
- Defined:
  - CPU writes to the ROM region with avs_debugaccess=0 are discarded but still acknowledged in CACK.
  - JTAG writes are always allowed.
- Undefined: no protection; all writes land.

Test Plan:
- Strobe take_action_ocimem_a with jdo[17:10]=0x10, jdo[35]=0 → address 0x10, no mon_valid. Then take_action_ocimem_b x3 with data 0xA5A5_0001..3 → RAM[0x10..0x12] hold those words, address=0x13.
- Address-load 0xFF then take_no_action_ocimem_a x2 → mon_valid twice, each 2 cycles after its strobe; MonDReg=RAM[0xFF] then RAM[0x00] (wrap).
- CPU write 0xDEADBEEF, byteenable 4'b0011 to 0x20 over 0x11223344, then CPU read of 0x20 → readdata 0x1122BEEF; waitrequest low exactly 1 cycle after each request.
- JTAG read pending in same cycle as avs_read → JTAG served first, mon_valid; CPU waitrequest held high, then CACK completes 2 cycles later than uncontended.
- Two take_no_action_ocimem_a on consecutive cycles → second dropped, jtag_overrun=1; next take_action_ocimem_a clears it. With OCIMEM_ROM_PROTECT_EN, a CPU write to 0xC0 with debugaccess=0 leaves the RAM unchanged; with debugaccess=1 the write lands.
- Assert reset during JRD → no mon_valid, MonDReg=0, waitrequest=1 next cycle.

Source files
------------

// File: rtl/nios2_debug_ocimem_ctrl_if.sv
// CPU-side Avalon-MM slave bundle for the OCI debug RAM controller.
// The debug-monitor master drives requests and the controller answers.
interface nios2_debug_ocimem_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              avs_debugaccess;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/nios2_debug_ocimem_ctrl.sv
// OCI debug RAM controller: serves JTAG bridge strobes and a CPU Avalon-MM slave on one RAM.
// Optional macro OCIMEM_ROM_PROTECT_EN blocks non-debug CPU writes to the top quarter.
module nios2_debug_ocimem_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [37:0]                     jdo,
  input  logic                            take_action_ocimem_a,
  input  logic                            take_action_ocimem_b,
  input  logic                            take_no_action_ocimem_a,
  nios2_debug_ocimem_ctrl_if.slave        avs,
  output logic [31:0]                     MonDReg,
  output logic                            mon_valid,
  output logic                            jtag_overrun
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StJrd, StCack} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pend_q;
  logic              pend_wr_q;
  logic              pend_inc_q;
  logic [31:0]       pend_data_q;
  logic [31:0]       mon_dreg_q;
  logic [31:0]       ram_rdata_q;
  logic              mon_valid_q;
  logic              overrun_q;
  logic              waitreq_q;

  logic [31:0] mem [Depth];

  logic strobe_any;
  logic pend_clear;
  logic accept;
  logic cpu_req;
  logic cpu_wr_ok;

  logic              ram_we;
  logic              ram_re;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  // A read stays pending until JRD retires it; a write retires in the IDLE cycle it lands.
  always_comb begin
    strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    pend_clear = (state_q == StJrd) || ((state_q == StIdle) && pend_q && pend_wr_q);
    accept     = strobe_any && (!pend_q || pend_clear);
    cpu_req    = avs.avs_read || avs.avs_write;
  end

`ifdef OCIMEM_ROM_PROTECT_EN
  assign cpu_wr_ok = avs.avs_debugaccess || (avs.avs_address[ADDR_W-1 -: 2] != 2'b11);
`else
  assign cpu_wr_ok = 1'b1;
  logic unused_debugaccess;
  assign unused_debugaccess = avs.avs_debugaccess;
`endif

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = 4'hf;
    ram_addr  = addr_q;
    ram_wdata = pend_data_q;
    if ((state_q == StIdle) && !reset) begin
      if (pend_q) begin
        ram_we = pend_wr_q;
        ram_re = !pend_wr_q;
      end else if (cpu_req) begin
        ram_addr  = avs.avs_address;
        ram_wdata = avs.avs_writedata;
        ram_be    = avs.avs_byteenable;
        ram_we    = avs.avs_write && cpu_wr_ok;
        ram_re    = avs.avs_read;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      if (ram_be[0]) mem[ram_addr][7:0]   <= ram_wdata[7:0];
      if (ram_be[1]) mem[ram_addr][15:8]  <= ram_wdata[15:8];
      if (ram_be[2]) mem[ram_addr][23:16] <= ram_wdata[23:16];
      if (ram_be[3]) mem[ram_addr][31:24] <= ram_wdata[31:24];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_inc_q  <= 1'b0;
      pend_data_q <= '0;
      mon_dreg_q  <= '0;
      ram_rdata_q <= '0;
      mon_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      waitreq_q   <= 1'b1;
    end else begin
      mon_valid_q <= 1'b0;
      waitreq_q   <= 1'b1;
      if (ram_re) ram_rdata_q <= mem[ram_addr];

      unique case (state_q)
        StIdle: begin
          if (pend_q && pend_wr_q) begin
            addr_q <= addr_q + ADDR_W'(1);
          end else if (pend_q) begin
            state_q <= StJrd;
          end else if (cpu_req) begin
            state_q   <= StCack;
            waitreq_q <= 1'b0;
          end
        end
        StJrd: begin
          mon_dreg_q  <= ram_rdata_q;
          mon_valid_q <= 1'b1;
          if (pend_inc_q) addr_q <= addr_q + ADDR_W'(1);
          state_q <= StIdle;
        end
        StCack:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (pend_clear) pend_q <= 1'b0;

      // A captured strobe overrides the retiring op; an address load beats any increment.
      if (accept) begin
        if (take_action_ocimem_b) begin
          pend_q      <= 1'b1;
          pend_wr_q   <= 1'b1;
          pend_data_q <= jdo[34:3];
        end else if (take_action_ocimem_a) begin
          addr_q     <= jdo[ADDR_W+9:10];
          pend_q     <= jdo[35];
          pend_wr_q  <= 1'b0;
          pend_inc_q <= 1'b0;
        end else begin
          pend_q     <= 1'b1;
          pend_wr_q  <= 1'b0;
          pend_inc_q <= 1'b1;
        end
      end

      if (take_action_ocimem_a) begin
        overrun_q <= 1'b0;
      end else if (strobe_any && !accept) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign MonDReg             = mon_dreg_q;
  assign mon_valid           = mon_valid_q;
  assign jtag_overrun        = overrun_q;
  assign avs.avs_readdata    = ram_rdata_q;
  assign avs.avs_waitrequest = waitreq_q;

endmodule
